demux_16b_10output: RTL and testbench
=====================================

Name: demux_16b_10output

Overview:
- Inverse of the datapath's 16-bit 10-input mux: accepts one 16-bit value plus an Op select and writes it into one of ten 16-bit destination holding registers (A..J).
- Sits on the accumulator processor's write-back side. It distributes ALU/accumulator results to their destinations and produces a one-cycle load strobe per destination.
- Valid/Ready handshake with a two-state FSM. Out-of-range Op codes are rejected and flagged.

Parameters:
- WIDTH, 16, data width of Input and of each destination register.
- NUM_OUT, 10, number of destinations; legal Op range is 0..NUM_OUT-1.

Ports:
- CLK  input  1  system clock, rising-edge active
- Reset_n  input  1  asynchronous, active-low reset
- Input  input  WIDTH  data to distribute
- Op  input  5  destination select; 0->A, 1->B, ... 9->J; 10..31 illegal
- Valid  input  1  request; Input and Op are sampled when Valid && Ready
- Ready  output  1  block can accept a request this cycle
- A, B, C, D, E, F, G, H, I, J  output  WIDTH each  registered destination values
- Load  output  NUM_OUT  one-hot write strobe; bit k pulses when destination k updates
- Err  output  1  illegal-Op indication
- Clear  input  1  clears sticky Err (used only with the optional feature; ignored otherwise)

Behaviour:
- Reset (Reset_n low, asynchronous): A..J=0, Load=0, Err=0, Ready=1, FSM=IDLE, internal capture registers=0.
- Reset release is synchronous to the next CLK edge. A request presented during reset is lost.
- FSM states:
  - IDLE: Ready=1. On Valid && Ready, capture Input and Op, go to WRITE. Otherwise stay in IDLE.
  - WRITE: Ready=0. This is the cycle after acceptance.
    - If captured Op < NUM_OUT: destination[Op] <= captured Input, Load[Op]=1 for exactly this cycle, Err=0.
    - If captured Op >= NUM_OUT: no destination changes, Load=0, Err=1 for this cycle.
    - Always return to IDLE on the next edge.
- Latency: acceptance at edge N; destination register and Load visible after edge N+1.
- Throughput: one request every 2 cycles. Valid asserted during WRITE is ignored; the requester must hold Valid until it sees Ready high.
- Load is one-hot or zero, never multi-hot. Outside WRITE, Load=0.
- Destinations not selected hold their values indefinitely. Only Reset_n clears them.
- Op width is 5 bits. Ops 10..15 are 4-bit-reachable illegal codes and 16..31 are also illegal; all illegal codes are treated identically.
- Input is not truncated or extended: WIDTH in, WIDTH out.
- Back-to-back writes to the same destination: the second value overwrites the first; each write produces its own Load pulse.
- Reset asserted in WRITE: the write is aborted, destinations read 0, Load=0, Err=0, next state IDLE.
- Valid high for consecutive cycles while in IDLE with Ready=1: only the first cycle is accepted, because Ready drops in WRITE.

Optional Feature:
- Macro DEMUX_STICKY_ERR_EN.
- Defined:
  - Err sets on any illegal-Op WRITE and stays 1 until Clear is sampled high on a CLK edge, or until reset.
  - If Clear and a new illegal write occur on the same edge, set wins and Err remains 1.
  - Legal writes do not clear Err.
- Undefined: Err is the single-cycle pulse described above; the Clear input is ignored.

Test Plan:
- Reset: hold Reset_n=0 with Valid=1, Op=3, Input=13 -> A..J=0, Load=0, Err=0, Ready=1 throughout; no write after release until Valid is re-presented.
- Walk all legal Ops: Input=34555 Op=0, then 32489/1, 545/2, 13/3, 6452/4, 789/5, 564/6, 4565/7, 1/8, 4575/9 -> each destination holds its value one cycle after acceptance, Load pulses the matching single bit, other destinations unchanged, Ready=0 only in the WRITE cycle.
- Illegal Ops 10..15 and 31 with Input=16'hFFFF -> Load=0, all destinations unchanged, Err=1 for one cycle. With DEMUX_STICKY_ERR_EN, Err stays 1 until Clear=1 for one cycle, then returns to 0.
- Handshake: Valid held high 4 cycles with Op=2, Input changing 100,200,300,400 -> accepted at cycles 1 and 3 only; C=100 after first write, then C=300; two Load[2] pulses.
- Async reset mid-operation: assert Reset_n low between edges during WRITE of Op=9, Input=4575 -> J=0 immediately with no clock edge needed, Load=0, state IDLE after release.
- Overwrite: Op=5 Input=789 then Op=5 Input=1 -> F=789, then F=1; two separate Load[5] pulses.

Source files
------------

// File: rtl/demux_16b_10output.sv
// Write-back demultiplexer: routes one WIDTH-bit result into one of ten holding
// registers (A..J) with a one-hot Load strobe. Optional sticky Err via DEMUX_STICKY_ERR_EN.
module demux_16b_10output #(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = 10
) (
  input  logic               CLK,
  input  logic               Reset_n,
  input  logic [WIDTH-1:0]   Input,
  input  logic [4:0]         Op,
  input  logic               Valid,
  input  logic               Clear,
  output logic               Ready,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   C,
  output logic [WIDTH-1:0]   D,
  output logic [WIDTH-1:0]   E,
  output logic [WIDTH-1:0]   F,
  output logic [WIDTH-1:0]   G,
  output logic [WIDTH-1:0]   H,
  output logic [WIDTH-1:0]   I,
  output logic [WIDTH-1:0]   J,
  output logic [NUM_OUT-1:0] Load,
  output logic               Err
);

  // state | meaning
  // IDLE  | Ready=1, waiting for Valid; Input/Op captured on acceptance
  // WRITE | Ready=0, captured value committed to its destination on exit
  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [4:0] OP_LIMIT = 5'(NUM_OUT);

  state_t             state;
  logic [WIDTH-1:0]   cap_data;
  logic [4:0]         cap_op;
  logic [WIDTH-1:0]   dest [NUM_OUT];
  logic [NUM_OUT-1:0] load_q;
  logic               ready_q;
  logic               err_q;
  logic               legal;

  assign legal = (cap_op < OP_LIMIT);

`ifndef DEMUX_STICKY_ERR_EN
  logic unused_clear;
  assign unused_clear = Clear;
`endif

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      ready_q  <= 1'b1;
      cap_data <= '0;
      cap_op   <= '0;
      load_q   <= '0;
      err_q    <= 1'b0;
      for (int k = 0; k < NUM_OUT; k++) dest[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          load_q <= '0;
`ifdef DEMUX_STICKY_ERR_EN
          if (Clear) err_q <= 1'b0;
`else
          err_q <= 1'b0;
`endif
          if (Valid && ready_q) begin
            cap_data <= Input;
            cap_op   <= Op;
            ready_q  <= 1'b0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          for (int k = 0; k < NUM_OUT; k++) begin
            if (legal && (cap_op == k[4:0])) begin
              dest[k]   <= cap_data;
              load_q[k] <= 1'b1;
            end else begin
              load_q[k] <= 1'b0;
            end
          end
`ifdef DEMUX_STICKY_ERR_EN
          // A new illegal write takes priority over a simultaneous Clear.
          if (!legal)     err_q <= 1'b1;
          else if (Clear) err_q <= 1'b0;
`else
          err_q <= !legal;
`endif
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          load_q  <= '0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign Ready = ready_q;
  assign Load  = load_q;
  assign Err   = err_q;
  assign A = dest[0];
  assign B = dest[1];
  assign C = dest[2];
  assign D = dest[3];
  assign E = dest[4];
  assign F = dest[5];
  assign G = dest[6];
  assign H = dest[7];
  assign I = dest[8];
  assign J = dest[9];

endmodule

// File: tb/tb_demux_16b_10output.sv
// Self-checking bench for demux_16b_10output: table-driven write/illegal vectors
// plus directed handshake, overwrite and asynchronous-reset sequences.
module tb_demux_16b_10output;
  logic        CLK = 1'b0;
  logic        Reset_n;
  logic [15:0] Input;
  logic [4:0]  Op;
  logic        Valid;
  logic        Clear;
  logic        Ready;
  logic [15:0] A, B, C, D, E, F, G, H, I, J;
  logic [9:0]  Load;
  logic        Err;

  int checks   = 0;
  int failures = 0;
  logic [15:0] model [10];
  logic        sticky_model;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] data;
    logic [9:0]  exp_load;
    logic        exp_err;
  } vec_t;
  vec_t vecs [17];

  demux_16b_10output dut (
    .CLK(CLK), .Reset_n(Reset_n), .Input(Input), .Op(Op), .Valid(Valid),
    .Clear(Clear), .Ready(Ready),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H), .I(I), .J(J),
    .Load(Load), .Err(Err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dest_out(input int k);
    case (k)
      0: return A;  1: return B;  2: return C;  3: return D;  4: return E;
      5: return F;  6: return G;  7: return H;  8: return I;  default: return J;
    endcase
  endfunction

  task automatic chk_dests(input string name);
    for (int k = 0; k < 10; k++) chk($sformatf("%s_dest%0d", name, k), 32'(dest_out(k)), 32'(model[k]));
  endtask

  // Present one request, check the WRITE cycle, and stop just after the commit edge.
  task automatic send(input logic [4:0] op, input logic [15:0] data);
    int budget = 0;
    while (!Ready && budget < 20) begin
      tick();
      budget++;
    end
    if (!Ready) chk("ready_timeout", 32'(Ready), 32'd1);
    Valid = 1'b1;
    Op    = op;
    Input = data;
    tick();
    Valid = 1'b0;
    chk("write_ready_low", 32'(Ready), 32'd0);
    chk("write_load_zero", 32'(Load), 32'd0);
    tick();
  endtask

  initial begin
    vecs[0]  = '{5'd0,  16'd34555, 10'b0000000001, 1'b0};
    vecs[1]  = '{5'd1,  16'd32489, 10'b0000000010, 1'b0};
    vecs[2]  = '{5'd2,  16'd545,   10'b0000000100, 1'b0};
    vecs[3]  = '{5'd3,  16'd13,    10'b0000001000, 1'b0};
    vecs[4]  = '{5'd4,  16'd6452,  10'b0000010000, 1'b0};
    vecs[5]  = '{5'd5,  16'd789,   10'b0000100000, 1'b0};
    vecs[6]  = '{5'd6,  16'd564,   10'b0001000000, 1'b0};
    vecs[7]  = '{5'd7,  16'd4565,  10'b0010000000, 1'b0};
    vecs[8]  = '{5'd8,  16'd1,     10'b0100000000, 1'b0};
    vecs[9]  = '{5'd9,  16'd4575,  10'b1000000000, 1'b0};
    vecs[10] = '{5'd10, 16'hFFFF,  10'b0, 1'b1};
    vecs[11] = '{5'd11, 16'hFFFF,  10'b0, 1'b1};
    vecs[12] = '{5'd12, 16'hFFFF,  10'b0, 1'b1};
    vecs[13] = '{5'd13, 16'hFFFF,  10'b0, 1'b1};
    vecs[14] = '{5'd14, 16'hFFFF,  10'b0, 1'b1};
    vecs[15] = '{5'd15, 16'hFFFF,  10'b0, 1'b1};
    vecs[16] = '{5'd31, 16'hFFFF,  10'b0, 1'b1};
    for (int k = 0; k < 10; k++) model[k] = '0;
    sticky_model = 1'b0;

    // Reset held with a request pending: nothing may be written.
    Reset_n = 1'b0; Valid = 1'b1; Op = 5'd3; Input = 16'd13; Clear = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_ready", 32'(Ready), 32'd1);
      chk("rst_load", 32'(Load), 32'd0);
      chk("rst_err", 32'(Err), 32'd0);
    end
    chk_dests("rst");
    Valid = 1'b0;
    Reset_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_ready", 32'(Ready), 32'd1);
    chk("post_rst_load", 32'(Load), 32'd0);
    chk_dests("post_rst");

    for (int v = 0; v < 17; v++) begin
      send(vecs[v].op, vecs[v].data);
      if (vecs[v].exp_load != 0) model[vecs[v].op] = vecs[v].data;
`ifdef DEMUX_STICKY_ERR_EN
      sticky_model = sticky_model | vecs[v].exp_err;
      chk($sformatf("v%0d_err", v), 32'(Err), 32'(sticky_model));
`else
      chk($sformatf("v%0d_err", v), 32'(Err), 32'(vecs[v].exp_err));
`endif
      chk($sformatf("v%0d_load", v), 32'(Load), 32'(vecs[v].exp_load));
      chk($sformatf("v%0d_ready", v), 32'(Ready), 32'd1);
      chk_dests($sformatf("v%0d", v));
      tick();
      chk($sformatf("v%0d_load_after", v), 32'(Load), 32'd0);
`ifdef DEMUX_STICKY_ERR_EN
      chk($sformatf("v%0d_err_after", v), 32'(Err), 32'(sticky_model));
`else
      chk($sformatf("v%0d_err_after", v), 32'(Err), 32'd0);
`endif
    end

    // Clear for one cycle; Err must read 0 afterwards in either build.
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    sticky_model = 1'b0;
    chk("clear_err", 32'(Err), 32'd0);
    tick();
    chk("clear_err_hold", 32'(Err), 32'd0);

    // Valid held four cycles: only cycles 1 and 3 are accepted.
    Valid = 1'b1; Op = 5'd2; Input = 16'd100;
    tick();
    chk("hs1_ready", 32'(Ready), 32'd0);
    Input = 16'd200;
    tick();
    chk("hs2_c", 32'(C), 32'd100);
    chk("hs2_load", 32'(Load), 32'd4);
    chk("hs2_ready", 32'(Ready), 32'd1);
    Input = 16'd300;
    tick();
    chk("hs3_ready", 32'(Ready), 32'd0);
    chk("hs3_load", 32'(Load), 32'd0);
    chk("hs3_c", 32'(C), 32'd100);
    Input = 16'd400;
    tick();
    chk("hs4_c", 32'(C), 32'd300);
    chk("hs4_load", 32'(Load), 32'd4);
    Valid = 1'b0;
    tick();
    chk("hs5_c", 32'(C), 32'd300);
    chk("hs5_load", 32'(Load), 32'd0);
    chk("hs5_ready", 32'(Ready), 32'd1);
    model[2] = 16'd300;
    chk_dests("hs");

    // Overwrite the same destination twice.
    send(5'd5, 16'd789);
    chk("ow1_f", 32'(F), 32'd789);
    chk("ow1_load", 32'(Load), 32'd32);
    tick();
    send(5'd5, 16'd1);
    chk("ow2_f", 32'(F), 32'd1);
    chk("ow2_load", 32'(Load), 32'd32);
    model[5] = 16'd1;
    chk_dests("ow");

    // Asynchronous reset in the middle of a WRITE cycle.
    tick();
    send(5'd9, 16'd1234);
    chk("pre_async_j", 32'(J), 32'd1234);
    tick();
    Valid = 1'b1; Op = 5'd9; Input = 16'd4575;
    tick();
    Valid = 1'b0;
    chk("async_in_write", 32'(Ready), 32'd0);
    #2 Reset_n = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) model[k] = '0;
    chk("async_j_now", 32'(J), 32'd0);
    chk("async_load_now", 32'(Load), 32'd0);
    chk("async_ready_now", 32'(Ready), 32'd1);
    chk("async_err_now", 32'(Err), 32'd0);
    tick();
    Reset_n = 1'b1;
    repeat (2) tick();
    chk("async_post_j", 32'(J), 32'd0);
    chk("async_post_load", 32'(Load), 32'd0);
    chk("async_post_ready", 32'(Ready), 32'd1);
    chk_dests("async");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
